// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-2 stream demultiplexer.
package demux_pkg;

    localparam int DW_DEF     = 32;
    localparam int CNT_W_DEF  = 16;
    localparam int FIFO_DEPTH = 2;

    // Occupancy of a 2-entry channel buffer.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'(FIFO_DEPTH)
    } occ_t;

endpackage

// File: rtl/demux1t2_32_stream_fifo2.sv
// Two-entry FIFO. The head entry is always held in head_r, so the output
// data comes straight from a register. A second register holds the younger
// entry when the FIFO is full.
module fifo2_32
    import demux_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty
);

    occ_t          occ_r;
    logic [DW-1:0] head_r;
    logic [DW-1:0] tail_r;
    logic          pop_s;
    logic          push_s;

    // A pop needs an entry. A push needs a free slot, or a slot freed by a
    // pop at the same edge.
    assign pop_s  = pop & (occ_r != OCC_EMPTY);
    assign push_s = push & ((occ_r != OCC_FULL) | pop_s);

    // Update occupancy and the head/tail entry registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_r  <= OCC_EMPTY;
            head_r <= {DW{1'b0}};
            tail_r <= {DW{1'b0}};
        end else begin
            case (occ_r)
                OCC_EMPTY: begin
                    if (push_s) begin
                        head_r <= din;
                        occ_r  <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    case ({push_s, pop_s})
                        2'b11: head_r <= din;
                        2'b10: begin
                            tail_r <= din;
                            occ_r  <= OCC_FULL;
                        end
                        2'b01: occ_r <= OCC_EMPTY;
                        default: ;
                    endcase
                end
                OCC_FULL: begin
                    case ({push_s, pop_s})
                        2'b11: begin
                            head_r <= tail_r;
                            tail_r <= din;
                        end
                        2'b01: begin
                            head_r <= tail_r;
                            occ_r  <= OCC_ONE;
                        end
                        default: ;
                    endcase
                end
                default: occ_r <= OCC_EMPTY;
            endcase
        end
    end

    assign head  = head_r;
    assign full  = (occ_r == OCC_FULL);
    assign empty = (occ_r == OCC_EMPTY);

endmodule

// File: rtl/demux1t2_32_stream.sv
// 1-to-2 stream demultiplexer. Each input word is routed by ctrl into one
// of two independent 2-entry FIFOs. Each channel has a transfer counter.
// in_ready depends only on registered occupancy, so downstream ready never
// reaches the input handshake combinationally.
module demux1t2_32_stream
    import demux_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DW-1:0]    a,
    input  logic             ctrl,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [DW-1:0]    c0,
    output logic [DW-1:0]    c1,
    output logic             c0_valid,
    output logic             c1_valid,
    input  logic             c0_ready,
    input  logic             c1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic             full0_s;
    logic             full1_s;
    logic             empty0_s;
    logic             empty1_s;
    logic             accept_s;
    logic             push0_s;
    logic             push1_s;
    logic             pop0_s;
    logic             pop1_s;
    logic [CNT_W-1:0] cnt0_r;
    logic [CNT_W-1:0] cnt1_r;

    // A full target blocks the input, even if that FIFO pops at this edge.
    assign in_ready = ctrl ? ~full1_s : ~full0_s;
    assign accept_s = in_valid & in_ready;
    assign push0_s  = accept_s & ~ctrl;
    assign push1_s  = accept_s & ctrl;

    assign c0_valid = ~empty0_s;
    assign c1_valid = ~empty1_s;
    assign pop0_s   = c0_valid & c0_ready;
    assign pop1_s   = c1_valid & c1_ready;

    fifo2_32 #(.DW(DW)) u_fifo0 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push0_s),
        .pop   (pop0_s),
        .din   (a),
        .head  (c0),
        .full  (full0_s),
        .empty (empty0_s)
    );

    fifo2_32 #(.DW(DW)) u_fifo1 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push1_s),
        .pop   (pop1_s),
        .din   (a),
        .head  (c1),
        .full  (full1_s),
        .empty (empty1_s)
    );

    // Count completed output transfers per channel; the counters wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_r <= {CNT_W{1'b0}};
            cnt1_r <= {CNT_W{1'b0}};
        end else begin
            if (pop0_s) begin
                cnt0_r <= cnt0_r + CNT_W'(1'b1);
            end
            if (pop1_s) begin
                cnt1_r <= cnt1_r + CNT_W'(1'b1);
            end
        end
    end

    assign cnt0 = cnt0_r;
    assign cnt1 = cnt1_r;

endmodule

// File: tb/tb_demux1t2_32_stream.sv
// Directed self-checking bench for demux1t2_32_stream.
module tb_demux1t2_32_stream;

    localparam int DW    = 32;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [DW-1:0]    a;
    logic             ctrl;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    c0;
    logic [DW-1:0]    c1;
    logic             c0_valid;
    logic             c1_valid;
    logic             c0_ready;
    logic             c1_ready;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    demux1t2_32_stream #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .ctrl     (ctrl),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .c0       (c0),
        .c1       (c1),
        .c0_valid (c0_valid),
        .c1_valid (c1_valid),
        .c0_ready (c0_ready),
        .c1_ready (c1_ready),
        .cnt0     (cnt0),
        .cnt1     (cnt1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; a = 32'h0; ctrl = 1'b0; in_valid = 1'b0;
        c0_ready = 1'b0; c1_ready = 1'b0;
        #2;
        total++; if (c0_valid !== 1'b0) begin bad++; $display("FAIL reset_c0_valid got=%0h want=0", c0_valid); end
        total++; if (c1_valid !== 1'b0) begin bad++; $display("FAIL reset_c1_valid got=%0h want=0", c1_valid); end
        total++; if (cnt0 !== 16'h0) begin bad++; $display("FAIL reset_cnt0 got=%0h want=0", cnt0); end
        total++; if (cnt1 !== 16'h0) begin bad++; $display("FAIL reset_cnt1 got=%0h want=0", cnt1); end
        total++; if (c0 !== 32'h0) begin bad++; $display("FAIL reset_c0 got=%0h want=0", c0); end
        total++; if (c1 !== 32'h0) begin bad++; $display("FAIL reset_c1 got=%0h want=0", c1); end
        tick;
        rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0h want=1", in_ready); end
    endtask

    task automatic test_single;
        c0_ready = 1'b1; a = 32'h11111111; ctrl = 1'b0; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        total++; if (c0_valid !== 1'b1) begin bad++; $display("FAIL single_c0_valid got=%0h want=1", c0_valid); end
        total++; if (c0 !== 32'h11111111) begin bad++; $display("FAIL single_c0 got=%0h want=11111111", c0); end
        total++; if (c1_valid !== 1'b0) begin bad++; $display("FAIL single_c1_valid got=%0h want=0", c1_valid); end
        tick;
        total++; if (cnt0 !== 16'd1) begin bad++; $display("FAIL single_cnt0 got=%0h want=1", cnt0); end
        total++; if (c0_valid !== 1'b0) begin bad++; $display("FAIL single_c0_drained got=%0h want=0", c0_valid); end
        total++; if (c1_valid !== 1'b0) begin bad++; $display("FAIL single_c1_quiet got=%0h want=0", c1_valid); end
        c0_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        c1_ready = 1'b0; ctrl = 1'b1; in_valid = 1'b1; a = 32'hA;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_empty got=%0h want=1", in_ready); end
        tick;
        a = 32'hB;
        tick;
        a = 32'hC;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%0h want=0", in_ready); end
        total++; if (c1 !== 32'hA) begin bad++; $display("FAIL bp_head_a got=%0h want=a", c1); end
        c1_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full_popping got=%0h want=0", in_ready); end
        tick;
        total++; if (c1 !== 32'hB) begin bad++; $display("FAIL bp_head_b got=%0h want=b", c1); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after_pop got=%0h want=1", in_ready); end
        tick;
        in_valid = 1'b0;
        total++; if (c1 !== 32'hC) begin bad++; $display("FAIL bp_head_c got=%0h want=c", c1); end
        total++; if (cnt1 !== 16'd2) begin bad++; $display("FAIL bp_cnt1_mid got=%0h want=2", cnt1); end
        tick;
        total++; if (cnt1 !== 16'd3) begin bad++; $display("FAIL bp_cnt1 got=%0h want=3", cnt1); end
        total++; if (c1_valid !== 1'b0) begin bad++; $display("FAIL bp_c1_drained got=%0h want=0", c1_valid); end
        c1_ready = 1'b0;
    endtask

    task automatic test_other_channel;
        c0_ready = 1'b0; c1_ready = 1'b0;
        ctrl = 1'b1; in_valid = 1'b1; a = 32'hD;
        tick;
        a = 32'hE;
        tick;
        ctrl = 1'b0; a = 32'h5;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL oc_ready_ch0 got=%0h want=1", in_ready); end
        tick;
        in_valid = 1'b0;
        total++; if (c0 !== 32'h5 || c0_valid !== 1'b1) begin bad++; $display("FAIL oc_c0 got=%0h/%0h want=5/1", c0, c0_valid); end
        total++; if (c1 !== 32'hD || c1_valid !== 1'b1) begin bad++; $display("FAIL oc_c1_held got=%0h/%0h want=d/1", c1, c1_valid); end
        c0_ready = 1'b1;
        tick;
        total++; if (cnt0 !== 16'd2) begin bad++; $display("FAIL oc_cnt0 got=%0h want=2", cnt0); end
        total++; if (c1 !== 32'hD || cnt1 !== 16'd3) begin bad++; $display("FAIL oc_c1_unchanged got=%0h/%0h want=d/3", c1, cnt1); end
        c0_ready = 1'b0; c1_ready = 1'b1;
        tick;
        total++; if (c1 !== 32'hE) begin bad++; $display("FAIL oc_c1_second got=%0h want=e", c1); end
        tick;
        total++; if (c1_valid !== 1'b0 || cnt1 !== 16'd5) begin bad++; $display("FAIL oc_c1_drain got=%0h/%0h want=0/5", c1_valid, cnt1); end
        c1_ready = 1'b0;
    endtask

    task automatic test_push_pop;
        ctrl = 1'b0; a = 32'h1; in_valid = 1'b1; c0_ready = 1'b0;
        tick;
        a = 32'h2; c0_ready = 1'b1;
        total++; if (c0 !== 32'h1) begin bad++; $display("FAIL pp_head1 got=%0h want=1", c0); end
        tick;
        c0_ready = 1'b0; a = 32'h3;
        #1;
        total++; if (c0 !== 32'h2 || c0_valid !== 1'b1) begin bad++; $display("FAIL pp_head2 got=%0h/%0h want=2/1", c0, c0_valid); end
        total++; if (cnt0 !== 16'd3) begin bad++; $display("FAIL pp_cnt0 got=%0h want=3", cnt0); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL pp_occ_one got=%0h want=1", in_ready); end
        tick;
        in_valid = 1'b0;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL pp_occ_two got=%0h want=0", in_ready); end
        c0_ready = 1'b1;
        tick;
        total++; if (c0 !== 32'h3 || cnt0 !== 16'd4) begin bad++; $display("FAIL pp_head3 got=%0h/%0h want=3/4", c0, cnt0); end
        tick;
        total++; if (c0_valid !== 1'b0 || cnt0 !== 16'd5) begin bad++; $display("FAIL pp_drain got=%0h/%0h want=0/5", c0_valid, cnt0); end
        c0_ready = 1'b0;
    endtask

    task automatic test_wrap;
        logic [CNT_W-1:0] exp_cnt0;
        logic             will_pop;
        exp_cnt0 = 16'd5;
        ctrl = 1'b0; a = 32'hCAFE0000; in_valid = 1'b1; c0_ready = 1'b1;
        for (int i = 0; i < 70000 && exp_cnt0 != 16'hFFFF; i++) begin
            will_pop = c0_valid & c0_ready;
            tick;
            if (will_pop) exp_cnt0 = exp_cnt0 + 16'd1;
            a = a + 32'd1;
        end
        in_valid = 1'b0;
        total++; if (exp_cnt0 !== 16'hFFFF) begin bad++; $display("FAIL wrap_timeout got=%0h want=ffff", exp_cnt0); end
        total++; if (cnt0 !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload got=%0h want=ffff", cnt0); end
        total++; if (c0_valid !== 1'b1) begin bad++; $display("FAIL wrap_pending got=%0h want=1", c0_valid); end
        tick;
        total++; if (cnt0 !== 16'h0000) begin bad++; $display("FAIL wrap_cnt0 got=%0h want=0", cnt0); end
        total++; if (c0_valid !== 1'b0) begin bad++; $display("FAIL wrap_drained got=%0h want=0", c0_valid); end
        c0_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        c0_ready = 1'b0; c1_ready = 1'b0; in_valid = 1'b1;
        ctrl = 1'b0; a = 32'h21; tick;
        a = 32'h22; tick;
        ctrl = 1'b1; a = 32'h31; tick;
        a = 32'h32; tick;
        in_valid = 1'b0;
        #1;
        total++; if (in_ready !== 1'b0 || c0_valid !== 1'b1 || c1_valid !== 1'b1) begin bad++; $display("FAIL rm_full got=%0h/%0h/%0h want=0/1/1", in_ready, c0_valid, c1_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (c0_valid !== 1'b0 || c1_valid !== 1'b0) begin bad++; $display("FAIL rm_valids got=%0h/%0h want=0/0", c0_valid, c1_valid); end
        total++; if (cnt0 !== 16'h0 || cnt1 !== 16'h0) begin bad++; $display("FAIL rm_counts got=%0h/%0h want=0/0", cnt0, cnt1); end
        total++; if (c0 !== 32'h0 || c1 !== 32'h0) begin bad++; $display("FAIL rm_data got=%0h/%0h want=0/0", c0, c1); end
        tick;
        rst_n = 1'b1; ctrl = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1 || c1_valid !== 1'b0) begin bad++; $display("FAIL rm_release got=%0h/%0h want=1/0", in_ready, c1_valid); end
        tick;
        total++; if (c0_valid !== 1'b0 || c1_valid !== 1'b0) begin bad++; $display("FAIL rm_no_survivor got=%0h/%0h want=0/0", c0_valid, c1_valid); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_backpressure;
        test_other_channel;
        test_push_pop;
        test_wrap;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/demux1t2_32_stream.md
DEMUX1T2_32_STREAM -- requirements
Module: demux1t2_32_stream

Interface
REQ-001 SHALL have parameter DW, default 32, data width of input and both output channels.
REQ-002 SHALL have parameter CNT_W, default 16, width of each per-channel transfer counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port a, input, DW, input data word.
REQ-006 SHALL have port ctrl, input, 1, route select: 0 selects channel 0, 1 selects channel 1.
REQ-007 SHALL have port in_valid, input, 1, a and ctrl are valid.
REQ-008 SHALL have port in_ready, output, 1, block accepts the current input.
REQ-009 SHALL have ports c0 and c1, output, DW, channel 0 and channel 1 head data.
REQ-010 SHALL have ports c0_valid and c1_valid, output, 1, channel head data is valid.
REQ-011 SHALL have ports c0_ready and c1_ready, input, 1, downstream accepts the channel head.
REQ-012 SHALL have ports cnt0 and cnt1, output, CNT_W, count of completed output transfers per channel.

Function
REQ-013 SHALL buffer each channel in an independent 2-entry FIFO with in-order delivery.
REQ-014 SHALL drive in_ready high when the FIFO selected by the current ctrl holds fewer than 2 entries, using registered occupancy only; there SHALL be no combinational path from c0_ready or c1_ready to in_ready.
REQ-015 SHALL accept an input when in_valid and in_ready are both high, and write a into FIFO[ctrl] at that edge.
REQ-016 SHALL assert cX_valid exactly when FIFO X is non-empty; cX SHALL be the oldest entry of FIFO X.
REQ-017 SHALL provide a latency of 1 cycle: a word accepted at edge N is visible on cX with cX_valid at the cycle after edge N.
REQ-018 SHALL complete an output transfer on channel X when cX_valid and cX_ready are both high; the head is removed at that edge.
REQ-019 SHALL hold cX stable while cX_valid is high and cX_ready is low.
REQ-020 SHALL, on a simultaneous push and pop on the same FIFO, leave occupancy unchanged and preserve order.
REQ-021 SHALL keep in_ready low when the selected FIFO is full, even if that FIFO pops in the same cycle.
REQ-022 SHALL stall only the input while the input targets a full channel; the other channel SHALL continue draining.
REQ-023 SHALL ignore cX_ready while cX_valid is low: no pop and no count.
REQ-024 SHALL increment cntX by 1 on every channel-X output transfer, wrapping from 2^CNT_W-1 to 0.
REQ-025 SHALL treat a and ctrl as don't-care while in_valid is low.

Reset
REQ-026 SHALL, while rst_n is low and independent of clk, force both FIFOs empty, c0_valid = c1_valid = 0, cnt0 = cnt1 = 0, and c0 = c1 = 0.
REQ-027 SHALL drive in_ready high in the first cycle after rst_n deasserts.
REQ-028 SHALL discard buffered data when reset is asserted mid-operation; no partial transfer survives reset.

Structure
REQ-029 SHALL place the DW default, CNT_W default and FIFO depth constant (2) in a shared package, demux_pkg.
REQ-030 SHALL implement each channel buffer as one instance of the sub-module fifo2_32 (2-entry FIFO with push, pop, full, empty and head), instantiated twice.
REQ-031 SHALL keep routing, in_ready generation and the counters in the top module.

Verification
REQ-032 SHALL cover: reset, then send a=0x11111111 with ctrl=0, with c0_ready=1 -> c0=0x11111111 and c0_valid high 1 cycle later, cnt0=1, c1_valid stays 0.
REQ-033 SHALL cover: hold c1_ready=0 and send 0xA, 0xB, 0xC with ctrl=1 -> in_ready low after 2 accepts; then raise c1_ready -> delivery 0xA then 0xB, 0xC accepted only after the first pop is registered, cnt1=3.
REQ-034 SHALL cover: channel 1 full and stalled while a ctrl=0 word 0x5 is sent -> 0x5 is accepted and delivered on c0; channel 1 contents unchanged.
REQ-035 SHALL cover: channel 0 at occupancy 1 with simultaneous push 0x2 and pop 0x1 -> occupancy stays 1, next head is 0x2.
REQ-036 SHALL cover: cnt0 preloaded to 0xFFFF by 65535 transfers, then one more transfer -> cnt0=0x0000.
REQ-037 SHALL cover: assert rst_n low asynchronously with both FIFOs holding 2 entries -> valids, counts and outputs 0 immediately; in_ready=1 after release.
